// File: rtl/pe_num_pkg.sv
// rtl/pe_num_pkg.sv - sign-magnitude word types and two's-complement conversion for the PE datapath
package pe_num_pkg;

  // PE operand magnitude width; the converter's SIZE tracks this value
  localparam int SM_SIZE = 4;
  localparam int SM_IN_W = SM_SIZE + 2;
  localparam logic [SM_SIZE-1:0] SM_MAG_MAX = '1;

  typedef struct packed {
    logic               sign;
    logic [SM_SIZE-1:0] mag;
  } sm_word_t;

  typedef struct packed {
    sm_word_t word;
    logic     sat;
  } sm_conv_t;

  // Magnitude is taken at full input width so the most negative input
  // does not wrap; anything above SM_MAG_MAX clamps and raises sat.
  function automatic sm_conv_t tc2sm(input logic [SM_IN_W-1:0] v);
    sm_conv_t           r;
    logic [SM_IN_W-1:0] m;
    m           = v[SM_IN_W-1] ? (~v + SM_IN_W'(1)) : v;
    r.word.sign = v[SM_IN_W-1];
    r.sat       = (m > SM_IN_W'(SM_MAG_MAX));
    r.word.mag  = r.sat ? SM_MAG_MAX : m[SM_SIZE-1:0];
    return r;
  endfunction

endpackage

// File: rtl/pe_pipe_reg.sv
// rtl/pe_pipe_reg.sv - single valid/ready register slice
module pe_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Slice may load when empty or when its current word leaves this cycle
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next state: data only moves on a real load so a stalled word holds
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // State register, cleared asynchronously so in-flight words are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pe_tc2sm_pack.sv
// rtl/pe_tc2sm_pack.sv - two-stage two's-complement to saturating sign-magnitude converter
module pe_tc2sm_pack
  import pe_num_pkg::*;
#(
  parameter int SIZE  = SM_SIZE,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE+1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [SIZE-1:0]  out_mag,
  output logic             out_sat,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);

  localparam int IN_W = SIZE + 2;
  localparam int OW   = SIZE + 2;

  logic            s1_valid, s2_in_ready;
  logic [IN_W-1:0] s1_data;
  logic [OW-1:0]   s2_in, s2_data;
  sm_conv_t        conv;
  logic            sat_xfer;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // S1 captures the raw two's-complement word
  pe_pipe_reg #(.W(IN_W)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(s1_valid),
    .out_ready(s2_in_ready),
    .out_data (s1_data)
  );

  assign conv  = tc2sm(s1_data);
  assign s2_in = {conv.word.sign, conv.word.mag, conv.sat};

  // S2 holds the converted word presented downstream
  pe_pipe_reg #(.W(OW)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_valid),
    .in_ready (s2_in_ready),
    .in_data  (s2_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_data)
  );

  assign out_sign  = s2_data[OW-1];
  assign out_mag   = s2_data[SIZE:1];
  assign out_sat   = s2_data[0];
  assign sat_xfer  = out_valid && out_ready && out_sat;
  assign sat_count = cnt_q;

  // Saturation counter: clear wins but still counts a coincident saturated word
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = CNT_W'(sat_xfer);
    end else if (sat_xfer && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_pe_tc2sm_pack.sv
// tb/tb_pe_tc2sm_pack.sv - randomized and directed bench for pe_tc2sm_pack
module tb_pe_tc2sm_pack;

  localparam int SIZE  = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SIZE+1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [SIZE-1:0]  out_mag;
  logic             out_sat;
  logic             sat_clr;
  logic [CNT_W-1:0] sat_count;

  pe_tc2sm_pack #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sign (out_sign),
    .out_mag  (out_mag),
    .out_sat  (out_sat),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [5:0] exp_q[$];
  int         push_q[$];
  bit         shown = 0;
  bit         lat_chk = 0;
  bit         prev_stall = 0;
  int         model_cnt = 0;
  bit         acc;
  bit         saw_stall;
  int         sent;
  logic [5:0] bp_vals[10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed value -> |value|, clamp to 15, flag clamp; packed {sign,mag,sat}
  function automatic logic [5:0] ref_conv(input logic [5:0] d);
    int   v;
    int   a;
    bit   s;
    bit   neg;
    logic [3:0] m;
    v   = int'($signed(d));
    neg = (v < 0);
    a   = neg ? -v : v;
    s   = (a > CMAX);
    m   = s ? 4'd15 : 4'(a);
    return {neg, m, s};
  endfunction

  // One clock: sample just after inputs settle, score transfers, advance, check counter
  task automatic cycle(output bit accepted);
    bit         ix;
    bit         ox;
    bit         popped_sat;
    #1;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    popped_sat = 1'b0;
    if (prev_stall) check("stall_valid_hold", out_valid, 1);
    prev_stall = out_valid && !out_ready;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        check("out_word", {out_sign, out_mag, out_sat}, exp_q[0]);
        if (lat_chk && !shown) check("latency", cyc - push_q[0], 2);
        shown = 1;
      end
    end
    if (ox && exp_q.size() > 0) begin
      popped_sat = exp_q[0][0];
      void'(exp_q.pop_front());
      void'(push_q.pop_front());
      shown = 0;
    end
    if (sat_clr) model_cnt = (ox && popped_sat) ? 1 : 0;
    else if (ox && popped_sat && model_cnt < CMAX) model_cnt++;
    if (ix) begin
      exp_q.push_back(ref_conv(in_data));
      push_q.push_back(cyc);
    end
    accepted = ix;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("sat_count", sat_count, model_cnt);
  endtask

  task automatic send(input logic [5:0] d);
    bit a;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    cycle(a);
    check("send_accept", a, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) cycle(a);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", {out_sign, out_mag, out_sat}, 0);
    check("rst_sat_count", sat_count, 0);

    // Basic conversions, back to back, 2-cycle latency
    lat_chk = 1;
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = 6'b111011; cycle(acc);
    in_data = 6'b001111; cycle(acc);
    in_data = 6'b000000; cycle(acc);
    drain();

    // Saturating values
    send(6'b010100);
    send(6'b110000);
    send(6'b100000);
    drain();
    check("sat_count_three", sat_count, 3);

    // Backpressure: out_ready low on cycles 3..7 of the stream
    lat_chk = 0;
    for (int i = 0; i < 10; i++) bp_vals[i] = 6'($urandom_range(0, 63));
    sent = 0; saw_stall = 0;
    for (int c = 0; c < 40 && sent < 10; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = 1'b1;
      in_data   = bp_vals[sent];
      #1;
      if (!in_ready) saw_stall = 1;
      #0;
      cycle(acc);
      if (acc) sent++;
    end
    check("bp_all_sent", sent, 10);
    check("bp_in_ready_dropped", saw_stall, 1);
    drain();

    // Full throughput with out_ready high
    lat_chk = 1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 6'($urandom_range(0, 63));
      cycle(acc);
      check("tput_accept", acc, 1);
    end
    drain();

    // Counter saturates at all ones
    for (int i = 0; i < 20; i++) send((i % 2) ? 6'b100000 : 6'b010100);
    drain();
    check("cnt_hold_max", sat_count, 15);

    // Clear coincident with a saturated output transfer
    in_valid = 1'b1; in_data = 6'b010110; out_ready = 1'b0;
    cycle(acc);
    in_valid = 1'b0;
    for (int k = 0; k < 5 && !out_valid; k++) cycle(acc);
    check("clr_word_ready", out_valid, 1);
    sat_clr = 1'b1; out_ready = 1'b1;
    cycle(acc);
    check("clr_coincident", sat_count, 1);
    cycle(acc);
    check("clr_alone", sat_count, 0);
    sat_clr = 1'b0;

    // Reset mid-stream with a full pipe
    lat_chk = 0;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 6'b010100;
      cycle(acc);
    end
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_sat_count", sat_count, 0);
    exp_q.delete(); push_q.delete();
    shown = 0; prev_stall = 0; model_cnt = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sat_count", sat_count, 0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 6'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 2) != 0);
      sat_clr   = ($urandom_range(0, 19) == 0);
      cycle(acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
